// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader.
package prog_loader_pkg;

  // Loader FSM states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ORIGIN = 3'd1,
    ST_COUNT  = 3'd2,
    ST_DATA   = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } state_e;

  // A segment count of this value terminates the object stream
  localparam int unsigned END_MARK_COUNT = 32'd0;

  // True in the states that consume object-stream words
  function automatic logic is_loading(input state_e s);
    return (s == ST_ORIGIN) || (s == ST_COUNT) || (s == ST_DATA);
  endfunction

endpackage

// File: rtl/prog_addr_gen.sv
// Segment base/offset registers; produces base+offset and flags address-space overflow.
module prog_addr_gen #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_base_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic              clr_off_i,
  input  logic              inc_off_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [LEN_W-1:0]  off_o,
  output logic              ovf_o
);

  localparam int SUM_W = ADDR_W + 1;

  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  offset_q, offset_d;
  logic [SUM_W-1:0]  sum_s;

  // Next base/offset: load base on origin, clear offset at segment start, step per word
  always_comb begin
    base_d   = base_q;
    offset_d = offset_q;
    if (load_base_i) begin
      base_d = base_i;
    end else begin
      base_d = base_q;
    end
    if (clr_off_i) begin
      offset_d = {LEN_W{1'b0}};
    end else if (inc_off_i) begin
      offset_d = offset_q + LEN_W'(1);
    end else begin
      offset_d = offset_q;
    end
  end

  // Base/offset registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q   <= {ADDR_W{1'b0}};
      offset_q <= {LEN_W{1'b0}};
    end else begin
      base_q   <= base_d;
      offset_q <= offset_d;
    end
  end

  // The extra sum bit catches a segment running past the top of memory
  assign sum_s  = {1'b0, base_q} + SUM_W'(offset_q);
  assign addr_o = sum_s[ADDR_W-1:0];
  assign ovf_o  = sum_s[ADDR_W];
  assign off_o  = offset_q;

endmodule

// File: rtl/prog_loader.sv
// Object-stream program loader: parses origin/count/data segments into memory writes.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int ADDR_W   = 16,
  parameter int MAX_SEGS = 4,
  parameter int LEN_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic [ADDR_W-1:0] start_pc,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int               SEG_W   = $clog2(MAX_SEGS + 1);
  localparam logic [WIDTH-1:0] MAX_LEN = WIDTH'((1 << LEN_W) - 1);

  state_e            state_q, state_d;
  logic [SEG_W-1:0]  seg_q, seg_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] start_pc_q, start_pc_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              in_ready_q, in_ready_d;

  logic              accept_s, last_s;
  logic              load_base_s, clr_off_s, inc_off_s;
  logic [ADDR_W-1:0] gen_addr_s;
  logic [LEN_W-1:0]  gen_off_s;
  logic              gen_ovf_s;

  prog_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_base_i (load_base_s),
    .base_i      (ADDR_W'(in_data)),
    .clr_off_i   (clr_off_s),
    .inc_off_i   (inc_off_s),
    .addr_o      (gen_addr_s),
    .off_o       (gen_off_s),
    .ovf_o       (gen_ovf_s)
  );

  assign accept_s = in_valid && in_ready_q;
  assign last_s   = (gen_off_s == (count_q - LEN_W'(1)));

  // Next-state and output decode; registered outputs follow the next state
  always_comb begin
    state_d     = state_q;
    seg_d       = seg_q;
    count_d     = count_q;
    start_pc_d  = start_pc_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    err_d       = err_q;
    load_base_s = 1'b0;
    clr_off_s   = 1'b0;
    inc_off_s   = 1'b0;
    case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (start) begin
          state_d = ST_ORIGIN;
          err_d   = 1'b0;
          seg_d   = {SEG_W{1'b0}};
        end else begin
          state_d = state_q;
        end
      end
      ST_ORIGIN: begin
        if (accept_s) begin
          load_base_s = 1'b1;
          state_d     = ST_COUNT;
          if (seg_q == {SEG_W{1'b0}}) begin
            start_pc_d = ADDR_W'(in_data);
          end else begin
            start_pc_d = start_pc_q;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_COUNT: begin
        if (!accept_s) begin
          state_d = state_q;
        end else if (in_data == WIDTH'(END_MARK_COUNT)) begin
          state_d = ST_DONE;
        end else if (in_data > MAX_LEN) begin
          state_d = ST_ERROR;
          err_d   = 1'b1;
        end else begin
          count_d   = LEN_W'(in_data);
          clr_off_s = 1'b1;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (!accept_s) begin
          state_d = state_q;
        end else if (gen_ovf_s) begin
          state_d = ST_ERROR;
          err_d   = 1'b1;
        end else begin
          mem_we_d    = 1'b1;
          mem_addr_d  = gen_addr_s;
          mem_wdata_d = in_data;
          inc_off_s   = 1'b1;
          if (last_s) begin
            seg_d = seg_q + SEG_W'(1);
            if ((seg_q + SEG_W'(1)) == SEG_W'(MAX_SEGS)) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_ORIGIN;
            end
          end else begin
            state_d = state_q;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    done_d     = (state_d == ST_DONE);
    busy_d     = is_loading(state_d);
    in_ready_d = busy_d;
  end

  // State and output registers; reset drops any pending write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      seg_q       <= {SEG_W{1'b0}};
      count_q     <= {LEN_W{1'b0}};
      start_pc_q  <= {ADDR_W{1'b0}};
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {WIDTH{1'b0}};
      mem_we_q    <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      seg_q       <= seg_d;
      count_q     <= count_d;
      start_pc_q  <= start_pc_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      err_q       <= err_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign start_pc  = start_pc_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
